button_debouncer: RTL and testbench

- Consumes the 200 Hz sample strobe from the clock divider and turns NUM_BTN raw, bouncing push-button inputs into clean debounced levels.
- Also produces one-clk-cycle press and release pulses.
- Sits between the board button pins and the control FSMs and display logic.
- Whole block runs on the 100 MHz system clock. sample_tick is used only as an enable, never as a clock.

---
 rtl/button_debouncer.sv | 135 +++++++++++++
 tb/tb_button_debouncer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN raw push buttons sampled on a 200 Hz enable strobe and emits
// one-cycle press/release pulses. Define DEBOUNCE_REPEAT_EN to add auto-repeat pulses.
module button_debouncer #(
  parameter int NUM_BTN        = 4,
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_RATE    = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               any_pressed
);

  localparam int CNT_W = $clog2(STABLE_SAMPLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_SAMPLES - 1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] state_q, state_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic               any_q, any_d;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

  // A change is committed only after STABLE_SAMPLES consecutive disagreeing ticks.
  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sample_tick) begin
        if (sync2_q[i] != state_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            state_d[i]   = sync2_q[i];
            cnt_d[i]     = '0;
            press_d[i]   = sync2_q[i];
            release_d[i] = ~sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
    any_d = |state_d;
  end

  // NOTE: every flop, including the counter array, is reset so a button held
  // through reset is re-qualified from scratch; state uses <= so all flops
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W = $clog2(RMAX) + 1;

  logic [RCNT_W-1:0]  rcnt_q [NUM_BTN];
  logic [RCNT_W-1:0]  rcnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] later_q, later_d;   // 0: waiting for first repeat, 1: steady rate
  logic [NUM_BTN-1:0] repeat_q, repeat_d;

  always_comb begin
    logic [RCNT_W-1:0] rcnt_inc;
    rcnt_inc = '0;
    later_d  = later_q;
    repeat_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rcnt_d[i] = rcnt_q[i];
      if (sample_tick) begin
        if (press_d[i] || release_d[i]) begin
          rcnt_d[i]  = '0;
          later_d[i] = 1'b0;
        end else if (state_q[i]) begin
          rcnt_inc = rcnt_q[i] + 1'b1;
          if (rcnt_inc == (later_q[i] ? RCNT_W'(REPEAT_RATE) : RCNT_W'(REPEAT_DELAY))) begin
            repeat_d[i] = 1'b1;
            rcnt_d[i]   = '0;
            later_d[i]  = 1'b1;
          end else begin
            rcnt_d[i] = rcnt_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      later_q  <= '0;
      repeat_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) rcnt_q[i] <= '0;
    end else begin
      later_q  <= later_d;
      repeat_q <= repeat_d;
      for (int i = 0; i < NUM_BTN; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end

  assign btn_repeat = repeat_q;
`else
  assign btn_repeat = '0;
`endif

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign any_pressed = any_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: reset, bounce, release, simultaneous
// presses, mid-qualification reset and (with DEBOUNCE_REPEAT_EN) auto-repeat.
module tb_button_debouncer;

  logic       clk;
  logic       rst;
  logic       sample_tick;
  logic [3:0] btn_raw;
  logic [3:0] btn_state, btn_press, btn_release, btn_repeat;
  logic       any_pressed;

  int checks   = 0;
  int failures = 0;

  button_debouncer #(
    .NUM_BTN(4), .STABLE_SAMPLES(4), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .btn_raw(btn_raw),
    .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_pressed(any_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic clk_cycle();
    @(posedge clk);
    #1;
  endtask

  // Nine idle cycles (lets the synchroniser settle), then one sample tick.
  task automatic tick();
    repeat (9) clk_cycle();
    sample_tick = 1'b1;
    clk_cycle();
    sample_tick = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [3:0] st, input logic [3:0] pr,
                           input logic [3:0] rl, input logic any);
    check({tag, ".state"},   btn_state,   st);
    check({tag, ".press"},   btn_press,   pr);
    check({tag, ".release"}, btn_release, rl);
    check({tag, ".any"},     {3'b000, any_pressed}, {3'b000, any});
  endtask

  initial begin
    logic [3:0] exp_rep;
    rst = 1'b1;
    sample_tick = 1'b1;
    btn_raw = 4'hF;

    // Reset overrides sample_tick with all buttons held.
    repeat (3) clk_cycle();
    check_all("reset", 4'h0, 4'h0, 4'h0, 1'b0);
    check("reset.repeat", btn_repeat, 4'h0);
    rst = 1'b0;
    sample_tick = 1'b0;

    // Held buttons re-qualify as a press on the 4th tick.
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_all("hold_qual", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    tick();
    check_all("hold_commit", 4'hF, 4'hF, 4'h0, 1'b1);
    clk_cycle();
    check_all("hold_after", 4'hF, 4'h0, 4'h0, 1'b1);

    // Release all.
    btn_raw = 4'h0;
    repeat (3) tick();
    check_all("rel_all_pend", 4'hF, 4'h0, 4'h0, 1'b1);
    tick();
    check_all("rel_all_commit", 4'h0, 4'h0, 4'hF, 1'b0);

    // Bounce on btn 0: samples 1,0,1,1,1,1 -> commit on the 6th tick.
    btn_raw = 4'h1; tick(); check_all("bounce_t1", 4'h0, 4'h0, 4'h0, 1'b0);
    btn_raw = 4'h0; tick(); check_all("bounce_t2", 4'h0, 4'h0, 4'h0, 1'b0);
    btn_raw = 4'h1;
    for (int k = 3; k <= 5; k++) begin
      tick();
      check_all("bounce_pend", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    tick();
    check_all("bounce_commit", 4'h1, 4'h1, 4'h0, 1'b1);
    clk_cycle();
    check("bounce_pulse_end", btn_press, 4'h0);

    // Release btn 0, then press and release btn 2.
    btn_raw = 4'h0;
    repeat (4) tick();
    check_all("rel0", 4'h0, 4'h0, 4'h1, 1'b0);
    btn_raw = 4'h4;
    repeat (4) tick();
    check_all("press2", 4'h4, 4'h4, 4'h0, 1'b1);
    btn_raw = 4'h0;
    repeat (3) tick();
    check_all("rel2_pend", 4'h4, 4'h0, 4'h0, 1'b1);
    tick();
    check_all("rel2_commit", 4'h0, 4'h0, 4'h4, 1'b0);
    clk_cycle();
    check("rel2_pulse_end", btn_release, 4'h0);

    // Simultaneous press on btns 0 and 2.
    btn_raw = 4'b0101;
    repeat (4) tick();
    check_all("simul", 4'b0101, 4'b0101, 4'h0, 1'b1);

    // Raw toggling without any tick leaves outputs untouched.
    for (int k = 0; k < 30; k++) begin
      btn_raw = 4'(k) ^ 4'b1010;
      clk_cycle();
    end
    check_all("no_tick", 4'b0101, 4'h0, 4'h0, 1'b1);
    btn_raw = 4'h0;
    repeat (4) tick();
    check_all("simul_rel", 4'h0, 4'h0, 4'b0101, 1'b0);

    // Reset after 2 qualifying ticks discards progress.
    btn_raw = 4'h2;
    repeat (2) tick();
    check_all("mid_pend", 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b1;
    sample_tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clk_cycle();
      check_all("mid_rst", 4'h0, 4'h0, 4'h0, 1'b0);
    end
    rst = 1'b0;
    sample_tick = 1'b0;
    repeat (3) tick();
    check_all("mid_requal", 4'h0, 4'h0, 4'h0, 1'b0);
    tick();
    check_all("mid_commit", 4'h2, 4'h2, 4'h0, 1'b1);

    // Auto-repeat: press committed at T0 above; release starts after T0+9,
    // commits at T0+13 (a repeat slot that must stay silent).
    for (int k = 1; k <= 15; k++) begin
      if (k == 10) btn_raw = 4'h0;
      tick();
      exp_rep = 4'h0;
`ifdef DEBOUNCE_REPEAT_EN
      if (k >= 5 && k <= 12 && ((k - 5) % 2 == 0)) exp_rep = 4'h2;
`endif
      check($sformatf("repeat_t%0d", k), btn_repeat, exp_rep);
      if (k == 13) check_all("repeat_rel", 4'h0, 4'h0, 4'h2, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
